// File: rtl/aes_stream_sequencer_if.sv
// Stream and AES-core signals for aes_stream_sequencer, bundled for the sequencer (master) and its environment (slave).
// Valid/ready on both stream sides: a word moves on a rising edge only when valid and ready are both high;
// a source holds data, sop and eop stable while valid is high and ready is low.
interface aes_stream_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int AES_W  = 128
);
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic              snk_sop;
  logic              snk_eop;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic [AES_W-1:0]  aes_din;
  logic              aes_start;
  logic [AES_W-1:0]  aes_dout;
  logic              aes_done;

  modport master (
    input  snk_data, snk_valid, snk_sop, snk_eop,
    output snk_ready,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready,
    output aes_din, aes_start,
    input  aes_dout, aes_done
  );

  modport slave (
    output snk_data, snk_valid, snk_sop, snk_eop,
    input  snk_ready,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready,
    input  aes_din, aes_start,
    output aes_dout, aes_done
  );
endinterface

// File: rtl/aes_stream_sequencer.sv
// Passes the IP header through, packs payload into AES blocks, runs the core and re-serialises results.
// Optional AES_SEQ_TIMEOUT_EN adds an aes_done watchdog with a sticky err_timeout flag.
module aes_stream_sequencer #(
  parameter int DATA_W    = 32,
  parameter int AES_W     = 128,
  parameter int HDR_WORDS = 5,
  parameter int CNT_W     = 8
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  aes_stream_sequencer_if.master bus,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      word_idx,
  output logic                  err_timeout,
  output logic [2:0]            dbg_state
);
  localparam int WPB = AES_W / DATA_W;
  localparam int CW  = $clog2(WPB);
  localparam logic [CW-1:0]    LAST     = CW'(WPB - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_WORDS - 1);

  typedef enum logic [2:0] {IDLE, HDR, COLLECT, START, WAIT, EMIT, TOUT} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              last;
  logic [AES_W-1:0]  res;
  logic [AES_W-1:0]  din_next;
  logic [DATA_W-1:0] emit_word;
  logic [CNT_W-1:0]  idx_inc;
  logic              snk_fire, src_fire;
  logic              drop, discard, wait_hit;

  assign dbg_state = state;
  assign idx_inc   = (word_idx == '1) ? word_idx : word_idx + 1'b1;
  assign discard   = drop && !bus.snk_sop;
  assign src_fire  = bus.src_ready && (state == EMIT || state == TOUT);

  always_comb begin
    snk_fire = 1'b0;
    if (state == HDR)          snk_fire = bus.snk_valid && (discard || bus.src_ready);
    else if (state == COLLECT) snk_fire = bus.snk_valid;
  end

  // The first word of a block clears the rest, so a short block is zero-padded.
  always_comb begin
    din_next = (cnt == '0) ? '0 : bus.aes_din;
    for (int i = 0; i < WPB; i++)
      if (cnt == CW'(i)) din_next[(WPB-1-i)*DATA_W +: DATA_W] = bus.snk_data;
  end

  always_comb begin
    emit_word = '0;
    for (int i = 0; i < WPB; i++)
      if (cnt == CW'(i)) emit_word = res[(WPB-1-i)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.snk_ready = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.src_sop   = 1'b0;
    bus.src_eop   = 1'b0;
    bus.aes_start = 1'b0;
    case (state)
      IDLE: if (enable) state_n = HDR;
      HDR: begin
        if (discard) begin
          bus.snk_ready = 1'b1;
        end else begin
          bus.snk_ready = bus.src_ready;
          bus.src_valid = bus.snk_valid;
          bus.src_data  = bus.snk_data;
          bus.src_sop   = bus.snk_sop && (word_idx == '0);
          bus.src_eop   = bus.snk_eop;
          if (snk_fire) begin
            if (bus.snk_eop)               state_n = IDLE;
            else if (word_idx == HDR_LAST) state_n = COLLECT;
          end
        end
      end
      COLLECT: begin
        bus.snk_ready = 1'b1;
        if (snk_fire && (bus.snk_eop || cnt == LAST)) state_n = START;
      end
      START: begin
        bus.aes_start = 1'b1;
        state_n       = WAIT;
      end
      WAIT: begin
        if (bus.aes_done)  state_n = EMIT;
        else if (wait_hit) state_n = TOUT;
      end
      EMIT: begin
        bus.src_valid = 1'b1;
        bus.src_data  = emit_word;
        bus.src_eop   = last && (cnt == LAST);
        if (src_fire && cnt == LAST) begin
          if (!last)       state_n = COLLECT;
          else if (enable) state_n = HDR;
          else             state_n = IDLE;
        end
      end
      TOUT: begin
        bus.src_valid = 1'b1;
        bus.src_eop   = 1'b1;
        if (src_fire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last        <= 1'b0;
      res         <= '0;
      bus.aes_din <= '0;
      pkt_count   <= '0;
      word_idx    <= '0;
    end else begin
      case (state)
        HDR: if (snk_fire && !discard) begin
          cnt <= '0;
          if (bus.snk_eop) begin
            pkt_count <= pkt_count + 1'b1;
            word_idx  <= '0;
          end else begin
            word_idx <= idx_inc;
          end
        end
        COLLECT: if (snk_fire) begin
          bus.aes_din <= din_next;
          word_idx    <= idx_inc;
          cnt         <= cnt + 1'b1;
          last        <= bus.snk_eop;
        end
        WAIT: if (bus.aes_done) begin
          res <= bus.aes_dout;
          cnt <= '0;
        end
        EMIT: if (src_fire) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST && last) begin
            pkt_count <= pkt_count + 1'b1;
            word_idx  <= '0;
          end
        end
        TOUT: if (src_fire) word_idx <= '0;
        default: ;
      endcase
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  assign wait_hit = (wait_cnt == TW'(TIMEOUT_CYC - 1)) && !bus.aes_done;

  // After a timeout the rest of the stalled packet is swallowed up to the next sop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      drop        <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == WAIT && wait_hit) err_timeout <= 1'b1;
      if (state == TOUT && src_fire) drop <= 1'b1;
      else if (state == HDR && snk_fire && bus.snk_sop) drop <= 1'b0;
    end
  end
`else
  assign wait_hit    = 1'b0;
  assign drop        = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Randomised scoreboard bench for aes_stream_sequencer with a packet-level reference model and a model AES core.
module tb_aes_stream_sequencer;
  localparam int HDR_WORDS = 5;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [CNT_W-1:0] pkt_count, word_idx;
  logic err_timeout;
  logic [2:0] dbg_state;

  aes_stream_sequencer_if bus ();

  aes_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .pkt_count(pkt_count), .word_idx(word_idx),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [33:0]  exp_q[$];   // {sop, eop, data}
  logic [127:0] blk_q[$];
  logic [31:0]  pkt_w[$];
  logic         pkt_sop[$];
  int pkt_n = 0;
  int checks = 0;
  int errors = 0;
  int model_pkts = 0;
  int rdy_mode = 0;
  int aes_lat = 2;
  bit aes_busy = 0;
  bit abort = 0;

  function automatic logic [127:0] aes_model(input logic [127:0] x);
    return {x[95:0], x[127:96]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got timeout/none expected event", name);
  endtask

  // Reference: header words verbatim, payload zero-padded to whole blocks, each block through the AES model.
  task automatic expect_pkt();
    int np, nb, idx;
    logic [127:0] blk, r;
    for (int i = 0; i < pkt_n && i < HDR_WORDS; i++)
      exp_q.push_back({(i == 0) && pkt_sop[i], i == pkt_n - 1, pkt_w[i]});
    if (pkt_n > HDR_WORDS) begin
      np = pkt_n - HDR_WORDS;
      nb = (np + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        blk = '0;
        for (int k = 0; k < 4; k++) begin
          idx = HDR_WORDS + 4 * b + k;
          blk = {blk[95:0], (idx < pkt_n) ? pkt_w[idx] : 32'h0};
        end
        blk_q.push_back(blk);
        r = aes_model(blk);
        for (int k = 0; k < 4; k++)
          exp_q.push_back({1'b0, (b == nb - 1) && (k == 3), r[127 - 32 * k -: 32]});
      end
    end
    model_pkts++;
  endtask

  task automatic random_pkt(input int n);
    pkt_w.delete();
    pkt_sop.delete();
    pkt_n = n;
    for (int i = 0; i < n; i++) begin
      pkt_w.push_back($urandom);
      pkt_sop.push_back((i == 0) || ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic send_pkt(input int upto);
    int guard;
    if (abort) return;
    for (int i = 0; i < upto; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.snk_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      bus.snk_valid = 1'b1;
      bus.snk_data  = pkt_w[i];
      bus.snk_sop   = pkt_sop[i];
      bus.snk_eop   = (i == pkt_n - 1);
      guard = 0;
      forever begin
        @(negedge clk);
        if (bus.snk_ready) break;
        guard++;
        if (guard > 1000) break;
      end
      if (guard > 1000) begin
        fail("snk_ready_wait");
        abort = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    if (abort) return;
    while ((exp_q.size() != 0 || blk_q.size() != 0 || aes_busy) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      fail("drain");
      abort = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("pkt_count", pkt_count, model_pkts % 256);
    check("word_idx_end", word_idx, 0);
  endtask

  // Ready pattern: 0 always ready, 1 random, 2 toggling every cycle.
  initial begin
    bus.src_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.src_ready = 1'b1;
        1:       bus.src_ready = 1'($urandom_range(0, 1));
        default: bus.src_ready = ~bus.src_ready;
      endcase
    end
  end

  // Model AES core; sometimes also pulses a bogus done in the start cycle, which must be ignored.
  initial begin
    logic [127:0] blk;
    int lat;
    bus.aes_done = 1'b0;
    bus.aes_dout = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.aes_start && rst_n) begin
        blk = bus.aes_din;
        lat = aes_lat;
        aes_busy = 1;
        if ($urandom_range(0, 2) == 0) begin
          bus.aes_done = 1'b1;
          bus.aes_dout = ~aes_model(blk);
        end
        @(posedge clk);
        #1;
        bus.aes_done = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        bus.aes_done = 1'b1;
        bus.aes_dout = aes_model(blk);
        @(posedge clk);
        #1;
        bus.aes_done = 1'b0;
        aes_busy = 0;
      end
    end
  end

  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("src_hold", {bus.src_valid, bus.src_data}, {1'b1, hold_d});
      hold_v = bus.src_valid && !bus.src_ready;
      hold_d = bus.src_data;
      if (bus.src_valid && bus.src_ready) begin
        if (exp_q.size() == 0) fail("unexpected_src_word");
        else check("src_word", {bus.src_sop, bus.src_eop, bus.src_data}, exp_q.pop_front());
      end
      if (bus.aes_start) begin
        if (blk_q.size() == 0) fail("unexpected_aes_start");
        else check("aes_din", bus.aes_din, blk_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int guard;
    bus.snk_valid = 1'b0;
    bus.snk_data  = '0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_count", pkt_count, 0);
    check("rst_word_idx", word_idx, 0);
    check("rst_outputs", {bus.snk_ready, bus.src_valid, bus.src_sop, bus.src_eop, bus.aes_start, err_timeout}, 0);
    check("rst_aes_din", bus.aes_din, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // 9-word packet with one full payload block
    rdy_mode = 0;
    aes_lat  = 2;
    pkt_w = '{32'h45000024, 32'h00001234, 32'h40004011, 32'hC0A80001, 32'hC0A80002,
              32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    pkt_sop = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    pkt_n = 9;
    expect_pkt();
    check("model_block", blk_q[0], 128'h00112233445566778899AABBCCDDEEFF);
    send_pkt(pkt_n);
    drain();

    // 6 payload words: second block zero-padded
    rdy_mode = 1;
    random_pkt(11);
    expect_pkt();
    send_pkt(pkt_n);
    drain();

    // toggling ready through EMIT; enable dropped mid-packet
    rdy_mode = 2;
    random_pkt(13);
    expect_pkt();
    enable = 1'b0;
    send_pkt(pkt_n);
    drain();

    // disabled: sink must stay stalled
    rdy_mode = 0;
    bus.snk_valid = 1'b1;
    bus.snk_sop   = 1'b1;
    bus.snk_data  = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("disabled_stall", {bus.snk_ready, bus.src_valid}, 0);
    end
    @(posedge clk);
    #1;
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    enable = 1'b1;

    // eop on header word 3: no AES activity
    random_pkt(3);
    expect_pkt();
    send_pkt(pkt_n);
    drain();

    for (int p = 0; p < 20; p++) begin
      rdy_mode = $urandom_range(0, 2);
      aes_lat  = $urandom_range(0, 4);
      random_pkt($urandom_range(1, 17));
      expect_pkt();
      send_pkt(pkt_n);
      drain();
    end

    // reset while waiting on the core
    if (!abort) begin
      rdy_mode = 0;
      aes_lat  = 30;
      random_pkt(12);
      expect_pkt();
      send_pkt(9);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("wait_rst_outputs", {bus.snk_ready, bus.src_valid, bus.src_sop, bus.src_eop, bus.aes_start, err_timeout}, 0);
      check("wait_rst_aes_din", bus.aes_din, 0);
      check("wait_rst_pkt_count", pkt_count, 0);
      check("wait_rst_word_idx", word_idx, 0);
      exp_q.delete();
      blk_q.delete();
      model_pkts = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      guard = 0;
      while (aes_busy && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      if (guard >= 200) fail("aes_model_idle");
      @(posedge clk);
      #1;
      rdy_mode = 1;
      aes_lat  = 1;
      random_pkt(10);
      expect_pkt();
      send_pkt(pkt_n);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
Sequences the AES core for packets arriving on the 32-bit MAC stream. The first 5 words (the 160-bit IP header) pass through unchanged. The block packs the payload into 128-bit blocks, drives the AES core with a start/done handshake, and serializes each result back onto the 32-bit stream. It sits between the TSE MAC Avalon-ST interface and the AES datapath; the peripheral register block drives its enable and reads its counters.

Parameters:
DATA_W, 32, stream word width (fixed by MAC core)
AES_W, 128, AES block width; AES_W/DATA_W = 4 words per block
HDR_WORDS, 5, IP header words passed through (160/32)
CNT_W, 8, word/packet counter width
TIMEOUT_CYC, 255, aes_done watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  from peripheral register; 0 = sink stalled at packet boundary
snk_data  in  DATA_W  input stream word
snk_valid  in  1  input word valid
snk_ready  out  1  block accepts input word
snk_sop  in  1  first word of packet
snk_eop  in  1  last word of packet
src_data  out  DATA_W  output stream word
src_valid  out  1  output word valid
src_ready  in  1  downstream accepts word
src_sop  out  1  first output word
src_eop  out  1  last output word
aes_din  out  AES_W  block to AES core
aes_start  out  1  one-cycle start pulse
aes_dout  in  AES_W  AES result
aes_done  in  1  one-cycle result-valid pulse
pkt_count  out  CNT_W  completed packets, wraps at 2^CNT_W
word_idx  out  CNT_W  current word index within packet, saturates at 255
err_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (rst_n low, async): state=IDLE. snk_ready, src_valid, src_sop, src_eop, aes_start, err_timeout are 0. aes_din, pkt_count, word_idx are 0. A packet in flight is dropped; the downstream sees no eop for it.
- A transfer occurs when valid&ready is high on a rising edge, on each side.
- IDLE: snk_ready=0. When enable=1, go to HDR. A snk_sop without a preceding packet end is only valid in HDR with word_idx=0; otherwise it is ignored (the word is accepted and treated as payload).
- HDR: combinational pass-through. src_data=snk_data, src_valid=snk_valid, snk_ready=src_ready, sop/eop forwarded. word_idx increments per transfer. After HDR_WORDS transfers go to COLLECT. If eop arrives during HDR, the packet ends: pkt_count+1, go to IDLE.
- COLLECT: snk_ready=1, src_valid=0. Words shift into aes_din; the first word lands in [127:96] and the fourth in [31:0]. After the 4th word, or on eop with 1-3 words, go to START.
  - Partial block: missing low words are zero-filled and an internal last flag is set.
- START: aes_start=1 for exactly one cycle, then go to WAIT. aes_din is held stable until aes_done.
- WAIT: snk_ready=0. On aes_done, capture aes_dout and go to EMIT. An aes_done arriving in the same cycle as aes_start is ignored.
- EMIT: src_valid=1 and src_data=[127:96] first, then down to [31:0]. Advance on each src_ready. src_sop=0 always.
  - src_eop=1 on the 4th word if last; a zero-padded packet always grows to a multiple of 4 payload words.
  - After the 4th word: if last, pkt_count+1 and go to IDLE (or HDR if enable still 1); else go to COLLECT.
- enable deasserted mid-packet takes effect only at the packet end.
- Total latency per block = 4 collect + 1 start + AES core latency + 1 capture + 4 emit cycles (with no backpressure).

Optional Feature:
AES_SEQ_TIMEOUT_EN
- Defined: a WAIT cycle counter runs.
  - On reaching TIMEOUT_CYC without aes_done: set err_timeout (sticky until reset), emit src_eop on a single zero word, go to IDLE. Input words are discarded until the next sop.
- Undefined: WAIT lasts indefinitely and err_timeout is tied to 0.

Test Plan:
- 9-word packet: header 0x45000024..., payload 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF -> 5 header words out unchanged at 0 latency. aes_din=0x00112233445566778899AABBCCDDEEFF with one aes_start pulse. 4 result words out, eop on the 9th, pkt_count=1.
- Payload of 6 words -> two AES starts. Second aes_din=W4,W5,0,0. Output 5+8 words, eop on the 13th.
- src_ready toggled 1/0 each cycle during EMIT -> no word lost or duplicated; src_data stable while src_valid&!src_ready.
- eop on header word 3 -> no aes_start, pkt_count+1, back to HDR.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. The next packet is processed normally with pkt_count starting at 0.
- AES_SEQ_TIMEOUT_EN, aes_done never asserted -> err_timeout=1 after 255 WAIT cycles, one zero word with eop, state=IDLE.
